lfm_chirp_sequencer: RTL and testbench

//   Sequences the DDS phase-increment input to generate stepped LFM chirps.

---
 rtl/lfm_pkg.sv | 20 ++
 rtl/lfm_step_counter.sv | 42 ++++
 rtl/lfm_chirp_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_lfm_chirp_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfm_pkg.sv
// Shared types and default sizes for the stepped-LFM chirp sequencer.
package lfm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_PARK = 3'd4
  } state_t;

  localparam int DEF_PINC_W = 32;
  localparam int DEF_CNT_W  = 21;
  localparam int DEF_STEP_W = 16;
  localparam int DEF_GAP_W  = 16;

  // Increment sent to the DDS on completion or abort; zero mutes it (DC).
  localparam logic [DEF_PINC_W-1:0] DEF_PARK_PINC = '0;

endpackage

// File: rtl/lfm_step_counter.sv
// Nested beat-within-step and step-within-chirp counters.
// The samples/steps inputs are expected to be at least 1; the top guarantees it.
module lfm_step_counter #(
  parameter int CNT_W  = 21,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [CNT_W-1:0]  samples,
  input  logic [STEP_W-1:0] steps,
  output logic              step_last,
  output logic              chirp_last
);

  logic [CNT_W-1:0]  beat_cnt;
  logic [STEP_W-1:0] step_cnt;

  // Flags describe the beat currently being presented, not yet counted.
  assign step_last  = (beat_cnt == samples - CNT_W'(1));
  assign chirp_last = step_last && (step_cnt == steps - STEP_W'(1));

  // Advance the beat count; roll into the step count at each step boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      step_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      step_cnt <= '0;
    end else if (enable) begin
      if (step_last) begin
        beat_cnt <= '0;
        step_cnt <= chirp_last ? '0 : step_cnt + STEP_W'(1);
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lfm_chirp_sequencer.sv
// Drives the DDS phase-increment stream to produce stepped LFM chirps,
// counting DDS output beats to decide when to step, repeat or park.
module lfm_chirp_sequencer
  import lfm_pkg::*;
#(
  parameter int                PINC_W    = DEF_PINC_W,
  parameter int                CNT_W     = DEF_CNT_W,
  parameter int                STEP_W    = DEF_STEP_W,
  parameter int                GAP_W     = DEF_GAP_W,
  parameter logic [PINC_W-1:0] PARK_PINC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PINC_W-1:0] cfg_pinc_start,
  input  logic [PINC_W-1:0] cfg_pinc_step,
  input  logic [CNT_W-1:0]  cfg_samples,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic [STEP_W-1:0] cfg_repeat,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic              pinc_tvalid,
  input  logic              pinc_tready,
  output logic [PINC_W-1:0] pinc_tdata,
  input  logic              smp_tvalid,
  input  logic              smp_tready,
  output logic              step_last,
  output logic              chirp_last,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] chirp_cnt,
  output logic              err_overrun
);

  state_t            state;
  logic [PINC_W-1:0] pinc_start_q;
  logic [PINC_W-1:0] pinc_step_q;
  logic [CNT_W-1:0]  samples_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] repeat_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              aborted;

  logic run_beat;
  logic cnt_step_last;
  logic cnt_chirp_last;
  logic start_ok;
  logic abort_busy;
  logic pinc_pending;
  logic pinc_accept;
  logic more_chirps;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + STEP_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] nz_samples(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [STEP_W-1:0] nz_steps(input logic [STEP_W-1:0] v);
    return (v == '0) ? STEP_W'(1) : v;
  endfunction

  assign run_beat     = smp_tvalid && smp_tready && (state == ST_RUN);
  assign start_ok     = (state == ST_IDLE) && start && !abort;
  assign abort_busy   = (state != ST_IDLE) && abort;
  assign pinc_accept  = pinc_tvalid && pinc_tready;
  assign pinc_pending = pinc_tvalid && !pinc_tready;
  // chirp_cnt is still the pre-increment value when this is consulted.
  assign more_chirps  = (repeat_q == '0) || (chirp_cnt != repeat_q - STEP_W'(1));

  assign step_last  = cnt_step_last && run_beat;
  assign chirp_last = cnt_chirp_last && run_beat;
  assign busy       = (state != ST_IDLE);

  lfm_step_counter #(
    .CNT_W  (CNT_W),
    .STEP_W (STEP_W)
  ) u_step_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok || abort_busy),
    .enable     (run_beat),
    .samples    (samples_q),
    .steps      (steps_q),
    .step_last  (cnt_step_last),
    .chirp_last (cnt_chirp_last)
  );

  // Sequencer FSM plus increment handshake; a new increment overwrites a
  // still-pending one rather than stalling, and flags the overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      pinc_tvalid  <= 1'b0;
      pinc_tdata   <= '0;
      pinc_start_q <= '0;
      pinc_step_q  <= '0;
      samples_q    <= CNT_W'(1);
      steps_q      <= STEP_W'(1);
      repeat_q     <= '0;
      gap_q        <= '0;
      gap_cnt      <= '0;
      chirp_cnt    <= '0;
      err_overrun  <= 1'b0;
      aborted      <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pinc_accept) pinc_tvalid <= 1'b0;

      if (state == ST_IDLE) begin
        if (start_ok) begin
          pinc_start_q <= cfg_pinc_start;
          pinc_step_q  <= cfg_pinc_step;
          samples_q    <= nz_samples(cfg_samples);
          steps_q      <= nz_steps(cfg_steps);
          repeat_q     <= cfg_repeat;
          gap_q        <= cfg_gap;
          chirp_cnt    <= '0;
          err_overrun  <= 1'b0;
          aborted      <= 1'b0;
          pinc_tdata   <= cfg_pinc_start;
          pinc_tvalid  <= 1'b1;
          state        <= ST_LOAD;
        end
      end else if (state == ST_PARK) begin
        if (abort) aborted <= 1'b1;
        if (pinc_accept) begin
          state <= ST_IDLE;
          done  <= !(aborted || abort);
        end
      end else if (abort) begin
        aborted     <= 1'b1;
        pinc_tdata  <= PARK_PINC;
        pinc_tvalid <= 1'b1;
        state       <= ST_PARK;
      end else begin
        case (state)
          ST_LOAD: begin
            if (pinc_accept) state <= ST_RUN;
          end
          ST_RUN: begin
            if (run_beat && cnt_step_last) begin
              if (!cnt_chirp_last) begin
                if (pinc_pending) err_overrun <= 1'b1;
                pinc_tdata  <= pinc_tdata + pinc_step_q;
                pinc_tvalid <= 1'b1;
              end else begin
                chirp_cnt <= sat_inc(chirp_cnt);
                if (more_chirps && (gap_q != '0)) begin
                  gap_cnt <= '0;
                  state   <= ST_GAP;
                end else begin
                  if (pinc_pending) err_overrun <= 1'b1;
                  pinc_tdata  <= more_chirps ? pinc_start_q : PARK_PINC;
                  pinc_tvalid <= 1'b1;
                  state       <= more_chirps ? ST_LOAD : ST_PARK;
                end
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt == gap_q - GAP_W'(1)) begin
              if (pinc_pending) err_overrun <= 1'b1;
              pinc_tdata  <= pinc_start_q;
              pinc_tvalid <= 1'b1;
              state       <= ST_LOAD;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfm_chirp_sequencer.sv
// Bench for lfm_chirp_sequencer: table of complete runs checked against a
// scoreboard of expected increments, plus hand sequences for stalls, aborts,
// overrun, continuous mode and asynchronous reset.
module tb_lfm_chirp_sequencer;

  localparam int PINC_W = 32;
  localparam int CNT_W  = 21;
  localparam int STEP_W = 16;
  localparam int GAP_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [PINC_W-1:0] cfg_pinc_start;
  logic [PINC_W-1:0] cfg_pinc_step;
  logic [CNT_W-1:0]  cfg_samples;
  logic [STEP_W-1:0] cfg_steps;
  logic [STEP_W-1:0] cfg_repeat;
  logic [GAP_W-1:0]  cfg_gap;
  logic              pinc_tvalid;
  logic              pinc_tready;
  logic [PINC_W-1:0] pinc_tdata;
  logic              smp_tvalid;
  logic              smp_tready;
  logic              step_last;
  logic              chirp_last;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] chirp_cnt;
  logic              err_overrun;

  always #5 clk = ~clk;

  lfm_chirp_sequencer #(
    .PINC_W    (PINC_W),
    .CNT_W     (CNT_W),
    .STEP_W    (STEP_W),
    .GAP_W     (GAP_W),
    .PARK_PINC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_pinc_start (cfg_pinc_start),
    .cfg_pinc_step  (cfg_pinc_step),
    .cfg_samples    (cfg_samples),
    .cfg_steps      (cfg_steps),
    .cfg_repeat     (cfg_repeat),
    .cfg_gap        (cfg_gap),
    .pinc_tvalid    (pinc_tvalid),
    .pinc_tready    (pinc_tready),
    .pinc_tdata     (pinc_tdata),
    .smp_tvalid     (smp_tvalid),
    .smp_tready     (smp_tready),
    .step_last      (step_last),
    .chirp_last     (chirp_last),
    .busy           (busy),
    .done           (done),
    .chirp_cnt      (chirp_cnt),
    .err_overrun    (err_overrun)
  );

  typedef struct {
    logic [31:0] start;
    logic [31:0] step;
    logic [31:0] samp;
    logic [31:0] steps;
    logic [31:0] rep;
    logic [31:0] gap;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pinc;
    bit          is_load;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_sl = 0;
  int n_cl = 0;
  int n_done = 0;
  bit sb_en = 1'b0;
  int eff_samp = 1;
  int eff_steps = 1;
  int eff_gap = 0;
  int beat_idx = 0;
  bit counting = 1'b0;
  int chirps_seen = 0;
  int last_cl_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event counters always run; the scoreboard model runs only when enabled.
  always @(negedge clk) begin
    bit bt;
    bit esl;
    bit ecl;
    int idx;
    sb_t e;
    cyc++;
    if (step_last)  n_sl++;
    if (chirp_last) n_cl++;
    if (done)       n_done++;
    if (sb_en) begin
      bt  = smp_tvalid & smp_tready;
      esl = 1'b0;
      ecl = 1'b0;
      if (counting && bt) begin
        idx      = beat_idx + 1;
        esl      = (idx % eff_samp) == 0;
        ecl      = (idx == eff_samp * eff_steps);
        beat_idx = idx;
      end
      chk("step_last", 32'(step_last), 32'(esl));
      chk("chirp_last", 32'(chirp_last), 32'(ecl));
      if (ecl) begin
        counting    = 1'b0;
        beat_idx    = 0;
        chirps_seen++;
        last_cl_cyc = cyc;
      end
      if (pinc_tvalid && pinc_tready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pinc_extra: got %0h with nothing expected", pinc_tdata);
        end else begin
          e = sbq.pop_front();
          chk("pinc_tdata", pinc_tdata, e.pinc);
          if (e.is_load) begin
            chk("chirp_cnt_at_load", 32'(chirp_cnt), chirps_seen);
            if (chirps_seen > 0) chk("gap_len", cyc - last_cl_cyc, eff_gap + 1);
            counting = 1'b1;
            beat_idx = 0;
          end
        end
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] st, input logic [31:0] sp,
                              input logic [31:0] sa, input logic [31:0] ns,
                              input logic [31:0] rp, input logic [31:0] gp);
    vec_t v;
    v.start = st; v.step = sp; v.samp = sa; v.steps = ns;
    v.rep = rp; v.gap = gp; v.exp_cnt = rp;
    return v;
  endfunction

  task automatic set_cfg(input vec_t v);
    cfg_pinc_start = v.start;
    cfg_pinc_step  = v.step;
    cfg_samples    = v.samp[CNT_W-1:0];
    cfg_steps      = v.steps[STEP_W-1:0];
    cfg_repeat     = v.rep[STEP_W-1:0];
    cfg_gap        = v.gap[GAP_W-1:0];
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int s, st, budget, d0, cl0, sl0;
    sb_t e;
    s  = (v.samp == 0) ? 1 : int'(v.samp);
    st = (v.steps == 0) ? 1 : int'(v.steps);
    eff_samp = s; eff_steps = st; eff_gap = int'(v.gap);
    chirps_seen = 0; counting = 1'b0; beat_idx = 0;
    sbq.delete();
    for (int r = 0; r < int'(v.rep); r++) begin
      for (int k = 0; k < st; k++) begin
        e.pinc    = v.start + v.step * 32'(k);
        e.is_load = (k == 0);
        sbq.push_back(e);
      end
    end
    e.pinc = 32'h0; e.is_load = 1'b0;
    sbq.push_back(e);
    set_cfg(v);
    pinc_tready = 1'b1; smp_tvalid = 1'b1; smp_tready = 1'b1;
    d0 = n_done; cl0 = n_cl; sl0 = n_sl;
    sb_en = 1'b1;
    pulse_start();
    budget = 0;
    while (n_done == d0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    chk("run_done", n_done - d0, 1);
    chk("run_chirp_cnt", 32'(chirp_cnt), v.exp_cnt);
    chk("run_chirp_lasts", n_cl - cl0, v.rep);
    chk("run_step_lasts", n_sl - sl0, int'(v.rep) * st);
    chk("run_sb_empty", sbq.size(), 0);
    chk("run_no_overrun", 32'(err_overrun), 0);
    repeat (4) @(posedge clk);
    chk("run_single_done", n_done - d0, 1);
    chk("run_idle", 32'(busy), 0);
    sb_en = 1'b0;
  endtask

  initial begin
    int d0, cl0, sl0, first, budget, exp_beats;
    logic [7:0] tvp;
    logic [7:0] trp;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_pinc_start = '0; cfg_pinc_step = '0; cfg_samples = '0;
    cfg_steps = '0; cfg_repeat = '0; cfg_gap = '0;
    pinc_tready = 1'b0; smp_tvalid = 1'b0; smp_tready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tvalid", 32'(pinc_tvalid), 0);
    chk("rst_tdata", pinc_tdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_chirp_cnt", 32'(chirp_cnt), 0);
    chk("rst_err", 32'(err_overrun), 0);
    chk("rst_step_last", 32'(step_last), 0);
    @(posedge clk); #1 reset = 1'b1;

    vecs[0] = mk(32'd1000, 32'd100, 4, 3, 1, 0);
    vecs[1] = mk(32'd1000, 32'd100, 4, 3, 2, 3);
    vecs[2] = mk(32'hFFFFFF00, 32'h200, 2, 2, 1, 0);
    vecs[3] = mk(32'd7, 32'd3, 0, 0, 1, 0);
    vecs[4] = mk(32'd5, 32'd7, 3, 4, 3, 1);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // LOAD stalled by pinc_tready, then abort during step 2.
    set_cfg(vecs[0]);
    pinc_tready = 1'b0; smp_tvalid = 1'b1; smp_tready = 1'b1;
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("load_hold_valid", 32'(pinc_tvalid), 1);
      chk("load_hold_data", pinc_tdata, 32'd1000);
    end
    @(posedge clk); #1 pinc_tready = 1'b1;
    @(negedge clk);
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (step_last && first == 0) first = i;
    end
    chk("first_step_after_stall", first, 4);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_park_data", pinc_tdata, 0);
    chk("abort_park_valid", 32'(pinc_tvalid), 1);
    chk("abort_busy", 32'(busy), 1);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_tvalid_low", 32'(pinc_tvalid), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);

    // Overrun with one-beat steps, then gated beat counting.
    set_cfg(mk(32'd10, 32'd5, 1, 8, 1, 0));
    pinc_tready = 1'b1; smp_tvalid = 1'b1; smp_tready = 1'b0;
    d0 = n_done;
    pulse_start();
    @(posedge clk); #1 pinc_tready = 1'b0; smp_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 smp_tready = 1'b0;
    @(negedge clk);
    chk("ovr_flag", 32'(err_overrun), 1);
    chk("ovr_latest", pinc_tdata, 32'd25);
    chk("ovr_valid", 32'(pinc_tvalid), 1);
    @(posedge clk); #1 pinc_tready = 1'b1;
    @(negedge clk);
    chk("ovr_deliver", pinc_tdata, 32'd25);
    chk("ovr_deliver_valid", 32'(pinc_tvalid), 1);
    tvp = 8'b1011_0111;
    trp = 8'b1101_1010;
    exp_beats = 0;
    for (int i = 0; i < 8; i++) if (tvp[i] && trp[i]) exp_beats++;
    sl0 = n_sl; cl0 = n_cl;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 smp_tvalid = tvp[i]; smp_tready = trp[i];
    end
    @(posedge clk); #1 smp_tvalid = 1'b0; smp_tready = 1'b0;
    @(posedge clk);
    chk("toggle_beats", n_sl - sl0, exp_beats);
    chk("toggle_no_chirp_end", n_cl - cl0, 0);
    #1 smp_tvalid = 1'b1; smp_tready = 1'b1;
    budget = 0;
    while (n_done == d0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    chk("ovr_run_done", n_done - d0, 1);
    chk("ovr_sticky", 32'(err_overrun), 1);
    chk("ovr_chirp_cnt", 32'(chirp_cnt), 1);

    // Continuous mode stopped by abort after three chirps.
    set_cfg(mk(32'd50, 32'd1, 1, 1, 0, 0));
    pinc_tready = 1'b1; smp_tvalid = 1'b1; smp_tready = 1'b1;
    d0 = n_done; cl0 = n_cl;
    pulse_start();
    budget = 0;
    while (n_cl - cl0 < 3 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("cont_chirp_cnt", 32'(chirp_cnt), 3);
    chk("cont_idle", 32'(busy), 0);
    chk("cont_no_done", n_done - d0, 0);

    // Asynchronous reset in the middle of a run.
    set_cfg(vecs[0]);
    pulse_start();
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_tvalid", 32'(pinc_tvalid), 0);
    chk("areset_tdata", pinc_tdata, 0);
    chk("areset_chirp_cnt", 32'(chirp_cnt), 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("areset_no_park", 32'(pinc_tvalid), 0);
    chk("areset_stay_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
